totient_display_scan: RTL and testbench

Downstream display stage for the totient sequencer. It captures each new 4-bit value from the sequencer's value strobe into a 4-entry history and time-multiplexes those entries onto a 4-digit common-segment 7-segment display. Each digit slot includes an anti-ghosting blank interval. Segment outputs keep the codebase's active-high A..G convention; digit enables are active-low.

---
 rtl/totient_pkg.sv | 37 +++
 rtl/seg7_hex_decoder.sv | 14 +
 rtl/totient_display_scan.sv | 158 +++++++++++++++
 tb/tb_totient_display_scan.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/totient_pkg.sv
// Shared display helpers for the totient codebase.
// Contents:
//   SEG_BLANK  - all segments off ({A..G} = 0)
//   AN_OFF     - all digit enables off (active-low)
//   SEG_TABLE  - 16-entry hex -> {A..G} active-high pattern table
//   hex_to_seg - looks up one pattern in SEG_TABLE
package totient_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Packed so that SEG_TABLE[n] is the pattern for hex digit n; the list
  // therefore runs from F (highest index) down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to 7-segment decoder.
// Ports:
//   hex  in  4  value 0..15
//   seg  out 7  {A..G}, active-high; every input value has a pattern
module seg7_hex_decoder
  import totient_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/totient_display_scan.sv
// Display stage for the totient sequencer: keeps the last four strobed values
// and time-multiplexes them onto a 4-digit 7-segment display with a blank
// interval at the start of every digit slot.
// Ports:
//   clk_0          in   clock, rising edge
//   R              in   asynchronous active-low reset
//   val_in[3:0]    in   value from sequencer
//   val_stb        in   one-cycle strobe qualifying val_in
//   clr            in   synchronous history clear
//   A..G           out  segments, active-high, registered
//   DP             out  decimal point (history overflow, shown on slot 3)
//   AN[3:0]        out  digit enables, active-low, registered; AN[0] rightmost
module totient_display_scan
  import totient_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       clk_0,
  input  logic       R,
  input  logic [3:0] val_in,
  input  logic       val_stb,
  input  logic       clr,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int              PC_W    = $clog2(SCAN_DIV);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0] PC_BLNK = PC_W'(BLANK_CYCLES);

  logic [PC_W-1:0] pc, pc_nxt;
  logic [1:0]      slot, slot_nxt;
  logic            pc_wrap;

  logic [3:0] h0, h1, h2, h3;
  logic [3:0] v, v_clr;
  logic       ovf, ovf_clr;

  logic [6:0] seg_lat, seg_lat_nxt;
  logic       en_lat, en_lat_nxt;
  logic       dp_lat, dp_lat_nxt;
  logic       snap;

  logic [3:0] h_sel;
  logic [6:0] seg_sel;

  logic [6:0] seg_q, seg_nxt;
  logic       dp_q, dp_nxt;
  logic [3:0] an_q, an_nxt;
  logic       active;

  // Prescaler and slot counter
  always_comb begin
    pc_wrap  = (pc == PC_LAST);
    pc_nxt   = pc_wrap ? '0 : pc + 1'b1;
    slot_nxt = pc_wrap ? slot + 2'd1 : slot;
  end

  // History entry for the slot currently being snapshotted
  always_comb begin
    h_sel = h0;
    case (slot)
      2'd0: h_sel = h0;
      2'd1: h_sel = h1;
      2'd2: h_sel = h2;
      2'd3: h_sel = h3;
      default: h_sel = h0;
    endcase
  end

  seg7_hex_decoder u_dec (
    .hex (h_sel),
    .seg (seg_sel)
  );

  // The snapshot at pc==0 freezes what this slot shows, so later strobes or
  // clears cannot tear the digit mid-slot.
  always_comb begin
    snap        = (pc == '0);
    seg_lat_nxt = snap ? seg_sel : seg_lat;
    en_lat_nxt  = snap ? v[slot] : en_lat;
    dp_lat_nxt  = snap ? ((slot == 2'd3) && ovf) : dp_lat;
  end

  // Outputs are computed from next-state pc/slot and next-state latches so the
  // registered pins change exactly on slot and blank boundaries.
  always_comb begin
    active  = (pc_nxt >= PC_BLNK) && en_lat_nxt;
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b0;
    if (active) begin
      an_nxt         = AN_OFF;
      an_nxt[slot_nxt] = 1'b0;
      seg_nxt        = seg_lat_nxt;
      dp_nxt         = dp_lat_nxt;
    end
  end

  // Clear is applied before a same-cycle load.
  always_comb begin
    v_clr   = clr ? 4'b0000 : v;
    ovf_clr = clr ? 1'b0 : ovf;
  end

  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      pc      <= '0;
      slot    <= 2'd0;
      h0      <= 4'd0;
      h1      <= 4'd0;
      h2      <= 4'd0;
      h3      <= 4'd0;
      v       <= 4'b0000;
      ovf     <= 1'b0;
      seg_lat <= SEG_BLANK;
      en_lat  <= 1'b0;
      dp_lat  <= 1'b0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b0;
      an_q    <= AN_OFF;
    end else begin
      pc      <= pc_nxt;
      slot    <= slot_nxt;
      seg_lat <= seg_lat_nxt;
      en_lat  <= en_lat_nxt;
      dp_lat  <= dp_lat_nxt;
      seg_q   <= seg_nxt;
      dp_q    <= dp_nxt;
      an_q    <= an_nxt;
      if (val_stb) begin
        h0  <= val_in;
        h1  <= h0;
        h2  <= h1;
        h3  <= h2;
        v   <= {v_clr[2:0], 1'b1};
        // A strobe into a full history pushes the oldest value out.
        ovf <= ovf_clr | (v_clr == 4'b1111);
      end else begin
        v   <= v_clr;
        ovf <= ovf_clr;
      end
    end
  end

  assign {A, B, C, D, E, F, G} = seg_q;
  assign DP = dp_q;
  assign AN = an_q;

endmodule

// File: tb/tb_totient_display_scan.sv
// Testbench for totient_display_scan (SCAN_DIV=4, BLANK_CYCLES=1).
module tb_totient_display_scan;

  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = 4 * SD;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic       clk_0 = 1'b0;
  logic       R = 1'b1;
  logic [3:0] val_in = 4'd0;
  logic       val_stb = 1'b0;
  logic       clr = 1'b0;
  logic       A, B, C, D, E, F, G, DP;
  logic [3:0] AN;

  int tests = 0;
  int fails = 0;

  totient_display_scan #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk_0   (clk_0),
    .R       (R),
    .val_in  (val_in),
    .val_stb (val_stb),
    .clr     (clr),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .E       (E),
    .F       (F),
    .G       (G),
    .DP      (DP),
    .AN      (AN)
  );

  always #5 clk_0 = ~clk_0;

  // Behavioural model: k counts cycles since reset release; the history is a
  // list of up to four values (newest at h[0]) with a fill count; each slot
  // shows the snapshot taken in its first cycle.
  typedef struct packed {
    int              k;
    int              cnt;
    logic [3:0][3:0] h;
    logic            ovf;
    logic [6:0]      sseg;
    logic            sen;
    logic            sdp;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_next(mstate_t cur, logic c, logic st, logic [3:0] vi);
    mstate_t n = cur;
    int s;
    if (cur.k % SD == 0) begin
      s      = (cur.k / SD) % 4;
      n.sen  = (s < cur.cnt);
      n.sseg = SEG_REF[cur.h[s]];
      n.sdp  = (s == 3) && cur.ovf;
    end
    if (c) begin
      n.cnt = 0;
      n.ovf = 1'b0;
    end
    if (st) begin
      if (n.cnt == 4) n.ovf = 1'b1;
      n.h = {n.h[2:0], vi};
      if (n.cnt < 4) n.cnt = n.cnt + 1;
    end
    n.k = cur.k + 1;
    return n;
  endfunction

  // {AN, A..G, DP} the display must show in the cycle described by cur
  function automatic logic [11:0] model_out(mstate_t cur);
    int pc, slot;
    logic [3:0] an;
    pc   = cur.k % SD;
    slot = (cur.k / SD) % 4;
    an   = 4'b1111;
    if (pc >= BL && cur.sen) begin
      an[slot] = 1'b0;
      return {an, cur.sseg, cur.sdp};
    end
    return {4'b1111, 7'b0000000, 1'b0};
  endfunction

  always @(posedge clk_0) begin
    if (!R) m <= '0;
    else    m <= model_next(m, clr, val_stb, val_in);
  end

  function automatic logic [11:0] dut_out();
    return {AN, A, B, C, D, E, F, G, DP};
  endfunction

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    logic [11:0] exp_v, got;
    @(negedge clk_0);
    exp_v = R ? model_out(m) : 12'hF00;
    got   = dut_out();
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL scan k=%0d AN=%b seg=%b DP=%b, expected AN=%b seg=%b DP=%b",
               m.k, got[11:8], got[7:1], got[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
    end
  endtask

  task automatic check_dut(string name, logic [3:0] an, logic [6:0] seg, logic dp);
    logic [11:0] got;
    got = dut_out();
    tests++;
    if (got !== {an, seg, dp}) begin
      fails++;
      $display("FAIL %s: AN=%b seg=%b DP=%b, expected AN=%b seg=%b DP=%b",
               name, got[11:8], got[7:1], got[0], an, seg, dp);
    end
  endtask

  task automatic check_model(string name, logic [3:0] an, logic [6:0] seg, logic dp);
    logic [11:0] mo;
    mo = model_out(m);
    tests++;
    if (mo !== {an, seg, dp}) begin
      fails++;
      $display("FAIL model_%s: AN=%b seg=%b DP=%b, expected AN=%b seg=%b DP=%b",
               name, mo[11:8], mo[7:1], mo[0], an, seg, dp);
    end
  endtask

  task automatic check_both(string name, logic [3:0] an, logic [6:0] seg, logic dp);
    check_dut(name, an, seg, dp);
    check_model(name, an, seg, dp);
  endtask

  // Tick until the cycle index within the frame equals ph (bounded).
  task automatic wait_k(int ph);
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if (m.k % FRAME == ph) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_k: phase %0d not reached, at k=%0d", ph, m.k);
  endtask

  task automatic pulse(logic [3:0] v, logic c);
    val_in  = v;
    val_stb = 1'b1;
    clr     = c;
    tick();
    val_stb = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic clear_only();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    // Reset, no strobes
    #2 R = 1'b0;
    #1 check_dut("reset_immediate", 4'b1111, 7'b0000000, 1'b0);
    repeat (3) tick();
    R = 1'b1;
    repeat (64) tick();
    wait_k(2);
    check_both("idle_slot0", 4'b1111, 7'b0000000, 1'b0);

    // Single value
    pulse(4'd2, 1'b0);
    repeat (FRAME) tick();
    wait_k(2);
    check_both("single_slot0", 4'b1110, 7'b1101101, 1'b0);
    wait_k(6);
    check_both("single_slot1", 4'b1111, 7'b0000000, 1'b0);
    wait_k(0);
    check_both("single_blank", 4'b1111, 7'b0000000, 1'b0);

    // Overflow history
    clear_only();
    pulse(4'd1, 1'b0);
    pulse(4'd1, 1'b0);
    pulse(4'd2, 1'b0);
    pulse(4'd2, 1'b0);
    pulse(4'd4, 1'b0);
    repeat (FRAME) tick();
    wait_k(2);
    check_both("ovf_slot0", 4'b1110, 7'b0110011, 1'b0);
    wait_k(6);
    check_both("ovf_slot1", 4'b1101, 7'b1101101, 1'b0);
    wait_k(10);
    check_both("ovf_slot2", 4'b1011, 7'b1101101, 1'b0);
    wait_k(14);
    check_both("ovf_slot3", 4'b0111, 7'b0110000, 1'b1);

    // Mid-slot strobe: slot 0 keeps the 4 until its next snapshot
    wait_k(2);
    pulse(4'd6, 1'b0);
    check_both("midslot_hold", 4'b1110, 7'b0110011, 1'b0);
    wait_k(2);
    check_both("midslot_new", 4'b1110, 7'b1011111, 1'b0);

    // Simultaneous clear and strobe
    pulse(4'd6, 1'b1);
    repeat (FRAME) tick();
    wait_k(2);
    check_both("clrstb_slot0", 4'b1110, 7'b1011111, 1'b0);
    wait_k(6);
    check_both("clrstb_slot1", 4'b1111, 7'b0000000, 1'b0);
    wait_k(14);
    check_both("clrstb_slot3", 4'b1111, 7'b0000000, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      val_in  = 4'($urandom_range(0, 15));
      val_stb = ($urandom_range(0, 3) == 0);
      clr     = ($urandom_range(0, 31) == 0);
      tick();
    end
    val_stb = 1'b0;
    clr     = 1'b0;

    // Async reset mid-scan
    pulse(4'd9, 1'b0);
    repeat (FRAME) tick();
    wait_k(2);
    check_both("pre_rst_slot0", 4'b1110, 7'b1111011, 1'b0);
    #2 R = 1'b0;
    #1 check_dut("async_rst", 4'b1111, 7'b0000000, 1'b0);
    repeat (3) tick();
    R = 1'b1;
    repeat (2 * FRAME) tick();
    wait_k(2);
    check_both("post_rst_empty", 4'b1111, 7'b0000000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
